// File: rtl/cve2_obi_pkg.sv
// cve2_obi_pkg: shared types and constants for the two-to-one OBI arbiter.
//   obi_owner_e : identifies which core port owns a request/response.
//   InstrBe     : byte enables presented to memory for instruction fetches.
package cve2_obi_pkg;

   typedef enum logic {
      OwnerInstr = 1'b0,
      OwnerData  = 1'b1
   } obi_owner_e;

   localparam logic [3:0] InstrBe = 4'hF;

endpackage

// File: rtl/cve2_obi_owner_fifo.sv
// cve2_obi_owner_fifo: in-order FIFO of 1-bit response owners.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   push, din    enqueue owner din (caller never pushes while full)
//   pop          dequeue head (caller never pops while empty)
//   head         owner at the head of the queue
//   full, empty  registered occupancy flags
module cve2_obi_owner_fifo
   import cve2_obi_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  obi_owner_e din,
   output obi_owner_e head,
   output logic       full,
   output logic       empty
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Depth-1:0] store;
   logic [PtrW-1:0]  wr_ptr, rd_ptr;
   logic [CntW-1:0]  count;

   assign full  = (count == CntW'(Depth));
   assign empty = (count == '0);
   assign head  = obi_owner_e'(store[rd_ptr]);

   // Pointers wrap modulo Depth so non-power-of-two depths work too.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         store  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            store[wr_ptr] <= din;
            wr_ptr        <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cve2_obi_arbiter.sv
// cve2_obi_arbiter: merges the core's instruction-fetch and data OBI ports
// onto one memory-side OBI master port. Responses are steered back to the
// issuing port through an in-order owner FIFO. Once a request is presented
// without grant, arbitration locks onto that owner until it is granted.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   instr_*               fetch port (req/gnt/rvalid/addr/rdata/err)
//   data_*                data port (req/gnt/rvalid/we/be/addr/wdata/rdata/err)
//   mem_*                 merged memory-side master port
// Parameter:
//   MaxOutstanding        maximum granted-but-unanswered transactions (>=1)
// Build option:
//   CVE2_OBI_ARB_RR_EN    round-robin on contention; fixed data priority
//                         when undefined.
module cve2_obi_arbiter
   import cve2_obi_pkg::*;
#(
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_req_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   input  logic [31:0] instr_addr_i,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i
);

   logic       lock_q;
   obi_owner_e lock_owner_q;
   obi_owner_e sel;
   obi_owner_e head;
   logic       full, empty;
   logic       any_req, push, pop;

   assign any_req = instr_req_i | data_req_i;

`ifdef CVE2_OBI_ARB_RR_EN
   obi_owner_e last_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     last_q <= OwnerInstr;
      else if (push) last_q <= sel;
   end
`endif

   // Owner selection. With neither port requesting, sel is irrelevant.
   always_comb begin
      sel = OwnerInstr;
      if (lock_q) begin
         sel = lock_owner_q;
      end else if (data_req_i && !instr_req_i) begin
         sel = OwnerData;
      end else if (instr_req_i && !data_req_i) begin
         sel = OwnerInstr;
      end else if (instr_req_i && data_req_i) begin
`ifdef CVE2_OBI_ARB_RR_EN
         sel = (last_q == OwnerData) ? OwnerInstr : OwnerData;
`else
         sel = OwnerData;
`endif
      end
   end

   // Registered full only: a same-cycle pop does not free a slot until
   // the next cycle, keeping req independent of rvalid.
   assign mem_req_o = any_req & ~full;
   assign push      = mem_req_o & mem_gnt_i;
   assign pop       = mem_rvalid_i & ~empty;

   // Payload is held at zero when no port requests.
   always_comb begin
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_addr_o  = 32'h0;
      mem_wdata_o = 32'h0;
      if (any_req) begin
         if (sel == OwnerData) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
         end else begin
            mem_be_o    = InstrBe;
            mem_addr_o  = instr_addr_i;
         end
      end
   end

   assign instr_gnt_o    = push & (sel == OwnerInstr);
   assign data_gnt_o     = push & (sel == OwnerData);
   assign instr_rvalid_o = pop & (head == OwnerInstr);
   assign data_rvalid_o  = pop & (head == OwnerData);
   assign instr_rdata_o  = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;
   assign instr_err_o    = mem_err_i;
   assign data_err_o     = mem_err_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lock_q       <= 1'b0;
         lock_owner_q <= OwnerInstr;
      end else if (mem_req_o && !mem_gnt_i) begin
         lock_q       <= 1'b1;
         lock_owner_q <= sel;
      end else if (push) begin
         lock_q       <= 1'b0;
      end
   end

   cve2_obi_owner_fifo #(
      .Depth (MaxOutstanding)
   ) u_owner_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (push),
      .pop   (pop),
      .din   (sel),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

`ifndef SYNTHESIS
   // Protocol checks; both conditions are tolerated by the logic above.
   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(mem_rvalid_i && empty))
            else $warning("cve2_obi_arbiter: mem_rvalid_i with no outstanding transaction");
         assert (!(lock_q && (lock_owner_q == OwnerData) && !data_req_i))
            else $warning("cve2_obi_arbiter: data_req_i dropped before grant");
         assert (!(lock_q && (lock_owner_q == OwnerInstr) && !instr_req_i))
            else $warning("cve2_obi_arbiter: instr_req_i dropped before grant");
      end
   end
`endif

endmodule

// File: tb/tb_cve2_obi_arbiter.sv
module tb_cve2_obi_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req, instr_gnt, instr_rvalid, instr_err;
   logic [31:0] instr_addr, instr_rdata;
   logic        data_req, data_gnt, data_rvalid, data_we, data_err;
   logic [3:0]  data_be;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        mem_req, mem_gnt, mem_rvalid, mem_we, mem_err;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cve2_obi_arbiter #(.MaxOutstanding(2)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .instr_req_i    (instr_req),
      .instr_gnt_o    (instr_gnt),
      .instr_rvalid_o (instr_rvalid),
      .instr_addr_i   (instr_addr),
      .instr_rdata_o  (instr_rdata),
      .instr_err_o    (instr_err),
      .data_req_i     (data_req),
      .data_gnt_o     (data_gnt),
      .data_rvalid_o  (data_rvalid),
      .data_we_i      (data_we),
      .data_be_i      (data_be),
      .data_addr_i    (data_addr),
      .data_wdata_i   (data_wdata),
      .data_rdata_o   (data_rdata),
      .data_err_o     (data_err),
      .mem_req_o      (mem_req),
      .mem_gnt_i      (mem_gnt),
      .mem_rvalid_i   (mem_rvalid),
      .mem_we_o       (mem_we),
      .mem_be_o       (mem_be),
      .mem_addr_o     (mem_addr),
      .mem_wdata_o    (mem_wdata),
      .mem_rdata_i    (mem_rdata),
      .mem_err_i      (mem_err)
   );

   typedef struct {
      string       name;
      logic        ir, dr, dwe, gnt, rv;
      logic [3:0]  dbe;
      logic [31:0] iaddr, daddr, dwdata, rdata;
      logic        e_req, e_we, e_igt, e_dgt, e_irv, e_drv;
      logic [3:0]  e_be;
      logic [31:0] e_addr, e_wdata, e_drdata;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      instr_req = 0; instr_addr = 0;
      data_req = 0; data_we = 0; data_be = 0; data_addr = 0; data_wdata = 0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      // name, ir dr dwe gnt rv, dbe, iaddr daddr dwdata rdata,
      // e_req e_we e_igt e_dgt e_irv e_drv, e_be, e_addr e_wdata e_drdata
      vecs[0] = '{"idle", 0,0,0,0,0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                  0,0,0,0,0,0, 4'h0, 32'h0, 32'h0, 32'h0};
      vecs[1] = '{"instr_only", 1,0,0,1,0, 4'h0, 32'h80, 32'h0, 32'h0, 32'h0,
                  1,0,1,0,0,0, 4'hF, 32'h80, 32'h0, 32'h0};
      vecs[2] = '{"data_write", 0,1,1,1,0, 4'h3, 32'h0, 32'h200, 32'hDEAD, 32'h0,
                  1,1,0,1,0,0, 4'h3, 32'h200, 32'hDEAD, 32'h0};
      vecs[3] = '{"both_nogrant", 1,1,0,0,0, 4'hC, 32'h80, 32'h300, 32'h1234, 32'h0,
                  1,0,0,0,0,0, 4'hC, 32'h300, 32'h1234, 32'h0};
      vecs[4] = '{"both_grant", 1,1,1,1,0, 4'hF, 32'h84, 32'h304, 32'h5678, 32'h0,
                  1,1,0,1,0,0, 4'hF, 32'h304, 32'h5678, 32'h0};
      vecs[5] = '{"spurious_rv", 0,0,0,0,1, 4'h0, 32'h0, 32'h0, 32'h0, 32'h55,
                  0,0,0,0,0,0, 4'h0, 32'h0, 32'h0, 32'h55};

      clear_inputs();
      rst = 1'b1;
      #2;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_gnts", {instr_gnt, data_gnt}, 0);
      chk("rst_rvalids", {instr_rvalid, data_rvalid}, 0);
      chk("rst_addr", mem_addr, 0);
      tick();
      rst = 1'b0;

      // Single-cycle vectors from reset state
      for (int i = 0; i < 6; i++) begin
         do_reset();
         instr_req = vecs[i].ir; data_req = vecs[i].dr; data_we = vecs[i].dwe;
         mem_gnt = vecs[i].gnt; mem_rvalid = vecs[i].rv; data_be = vecs[i].dbe;
         instr_addr = vecs[i].iaddr; data_addr = vecs[i].daddr;
         data_wdata = vecs[i].dwdata; mem_rdata = vecs[i].rdata;
         #1;
         chk({vecs[i].name, ".req"}, mem_req, vecs[i].e_req);
         chk({vecs[i].name, ".we"}, mem_we, vecs[i].e_we);
         chk({vecs[i].name, ".be"}, mem_be, vecs[i].e_be);
         chk({vecs[i].name, ".addr"}, mem_addr, vecs[i].e_addr);
         chk({vecs[i].name, ".wdata"}, mem_wdata, vecs[i].e_wdata);
         chk({vecs[i].name, ".igt"}, instr_gnt, vecs[i].e_igt);
         chk({vecs[i].name, ".dgt"}, data_gnt, vecs[i].e_dgt);
         chk({vecs[i].name, ".irv"}, instr_rvalid, vecs[i].e_irv);
         chk({vecs[i].name, ".drv"}, data_rvalid, vecs[i].e_drv);
         chk({vecs[i].name, ".drdata"}, data_rdata, vecs[i].e_drdata);
         tick();
      end

      // Fetch with response one cycle later
      do_reset();
      instr_req = 1; instr_addr = 32'h80; mem_gnt = 1;
      #1;
      chk("fetch.addr", mem_addr, 32'h80);
      chk("fetch.gnt", instr_gnt, 1);
      tick();
      instr_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h13;
      #1;
      chk("fetch.irv", instr_rvalid, 1);
      chk("fetch.rdata", instr_rdata, 32'h13);
      chk("fetch.drv", data_rvalid, 0);
      tick();

      // Contention with immediate grant and 1-cycle response
      do_reset();
      instr_req = 1; data_req = 1; mem_gnt = 1;
      instr_addr = 32'h80; data_addr = 32'h100;
      for (int c = 0; c < 4; c++) begin
         logic exp_d;
`ifdef CVE2_OBI_ARB_RR_EN
         exp_d = (c % 2 == 0);
`else
         exp_d = 1'b1;
`endif
         #1;
         chk($sformatf("contend%0d.dgt", c), data_gnt, exp_d);
         chk($sformatf("contend%0d.igt", c), instr_gnt, !exp_d);
         tick();
         mem_rvalid = 1;
      end

      // Lock holds while data stays ungranted, even after data_req drops
      do_reset();
      instr_req = 1; instr_addr = 32'h80;
      data_req = 1; data_addr = 32'h100;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("lock%0d.addr", c), mem_addr, 32'h100);
         tick();
      end
      data_req = 0;
      #1;
      chk("lock_drop.addr", mem_addr, 32'h100);
      chk("lock_drop.req", mem_req, 1);
      mem_gnt = 1;
      #1;
      chk("lock_gnt.dgt", data_gnt, 1);
      chk("lock_gnt.igt", instr_gnt, 0);
      tick();
      #1;
      chk("lock_after.addr", mem_addr, 32'h80);
      chk("lock_after.igt", instr_gnt, 1);
      tick();

      // Full: third request blocked, released the cycle after a response
      do_reset();
      instr_req = 1; instr_addr = 32'h40; mem_gnt = 1;
      #1; chk("full0.req", mem_req, 1);
      tick();
      #1; chk("full1.req", mem_req, 1);
      tick();
      #1;
      chk("full2.req", mem_req, 0);
      chk("full2.igt", instr_gnt, 0);
      mem_rvalid = 1;
      #1;
      chk("full_rv.req", mem_req, 0);
      chk("full_rv.irv", instr_rvalid, 1);
      tick();
      mem_rvalid = 0;
      #1;
      chk("full_rel.req", mem_req, 1);
      tick();

      // In-order responses: instr then data, err 0 then 1
      do_reset();
      instr_req = 1; instr_addr = 32'h80; mem_gnt = 1;
      tick();
      instr_req = 0; data_req = 1; data_addr = 32'h100;
      #1; chk("order.dgt", data_gnt, 1);
      tick();
      data_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_err = 0;
      #1;
      chk("order1.irv", instr_rvalid, 1);
      chk("order1.ierr", instr_err, 0);
      chk("order1.drv", data_rvalid, 0);
      tick();
      mem_err = 1;
      #1;
      chk("order2.drv", data_rvalid, 1);
      chk("order2.derr", data_err, 1);
      chk("order2.irv", instr_rvalid, 0);
      tick();

      // Reset with two outstanding, then spurious response
      do_reset();
      instr_req = 1; mem_gnt = 1;
      tick();
      tick();
      instr_req = 0; mem_gnt = 0;
      rst = 1;
      #1;
      chk("rst_mid.req", mem_req, 0);
      chk("rst_mid.rv", {instr_rvalid, data_rvalid}, 0);
      tick();
      rst = 0;
      mem_rvalid = 1;
      #1;
      chk("spur.rv", {instr_rvalid, data_rvalid}, 0);
      mem_rvalid = 0;
      instr_req = 1; mem_gnt = 1;
      #1; chk("post_rst0.req", mem_req, 1);
      tick();
      #1; chk("post_rst1.req", mem_req, 1);
      tick();
      #1; chk("post_rst2.req", mem_req, 0);
      clear_inputs();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
